// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: receives a standard I2S stream from a clock-master codec and presents
// left/right sample pairs on the system clock with a single-cycle valid pulse.
//
// Ports:
//   clk          system clock, at least 4x the au_bck frequency
//   rst_n        asynchronous active-low reset
//   enable       capture enable; low returns the receiver to idle
//   au_bck       serial bit clock from the codec (asynchronous)
//   au_ws        word select, 0 = left, 1 = right (asynchronous)
//   au_data      serial data, MSB first (asynchronous)
//   left_data    last complete left sample, left-justified
//   right_data   last complete right sample, left-justified
//   sample_valid one-clk pulse when a new left/right pair is presented
//   locked       high once word alignment has been acquired
//
// Optional feature, macro I2S_RX_PEAK_DETECT_EN:
//   peak_clr     zeroes peak_level on the next clk (wins over an update)
//   peak_level   running max of |left| and |right| (two's complement, saturating)

module i2s_rx_capture #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              au_bck,
  input  logic              au_ws,
  input  logic              au_data,
`ifdef I2S_RX_PEAK_DETECT_EN
  input  logic              peak_clr,
  output logic [DATA_W-1:0] peak_level,
`endif
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              locked
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StArm, StRunL, StRunR} state_e;

  // Synchroniser and bck-rise detection pipeline.
  logic [1:0] r_bck_sync;
  logic [1:0] r_ws_sync;
  logic [1:0] r_data_sync;
  logic       r_bck_prev;
  logic       r_rise;
  logic       r_ws_smp;
  logic       r_data_smp;
  logic       w_bck_rise;

  assign w_bck_rise = r_bck_sync[1] & ~r_bck_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bck_sync  <= '0;
      r_ws_sync   <= '0;
      r_data_sync <= '0;
      r_bck_prev  <= 1'b0;
      r_rise      <= 1'b0;
      r_ws_smp    <= 1'b0;
      r_data_smp  <= 1'b0;
    end else begin
      r_bck_sync  <= {r_bck_sync[0], au_bck};
      r_ws_sync   <= {r_ws_sync[0], au_ws};
      r_data_sync <= {r_data_sync[0], au_data};
      r_bck_prev  <= r_bck_sync[1];
      // ws/data travel alongside the rise strobe so they are consumed with it.
      r_rise      <= w_bck_rise;
      r_ws_smp    <= r_ws_sync[1];
      r_data_smp  <= r_data_sync[1];
    end
  end

  // Word assembly and framing state.
  state_e            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_hold;
  logic [CntW-1:0]   r_cnt;
  logic              r_left_seen;
  logic              r_ws_prev;
  logic              w_ws_chg;
  logic              w_cnt_full;
  logic              w_pair;
  logic [DATA_W-1:0] w_word;

  assign w_ws_chg   = r_rise & (r_ws_smp != r_ws_prev);
  assign w_cnt_full = (r_cnt == CntW'(DATA_W));
  assign w_pair     = enable & (r_state == StRunR) & w_ws_chg & r_left_seen;

  // Current word with this rise's bit dropped into its MSB-first slot; once the counter
  // saturates no slot matches and extra bits fall away.
  always_comb begin
    w_word = r_shift;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (r_cnt == CntW'(int'(DATA_W) - 1 - i)) begin
        w_word[i] = r_data_smp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_hold       <= '0;
      r_cnt        <= '0;
      r_left_seen  <= 1'b0;
      r_ws_prev    <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      // ws history is tracked in every state so the first edge after enable is seen.
      if (r_rise) begin
        r_ws_prev <= r_ws_smp;
      end
      if (!enable) begin
        r_state     <= StIdle;
        r_shift     <= '0;
        r_cnt       <= '0;
        r_left_seen <= 1'b0;
        locked      <= 1'b0;
      end else if (r_state == StIdle) begin
        r_state <= StArm;
      end else if (r_rise) begin
        if (w_ws_chg) begin
          r_shift <= '0;
          r_cnt   <= '0;
          unique case (r_state)
            StArm: begin
              // Partial word is discarded; alignment starts at this edge.
              locked  <= 1'b1;
              r_state <= r_ws_smp ? StRunR : StRunL;
            end
            StRunL: begin
              r_hold      <= w_word;
              r_left_seen <= 1'b1;
              r_state     <= StRunR;
            end
            StRunR: begin
              r_state <= StRunL;
              if (r_left_seen) begin
                left_data    <= r_hold;
                right_data   <= w_word;
                sample_valid <= 1'b1;
              end
            end
            StIdle: r_state <= StArm;
          endcase
        end else begin
          r_shift <= w_word;
          if (!w_cnt_full) begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
      end
    end
  end

`ifdef I2S_RX_PEAK_DETECT_EN
  localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MaxPos = ~MinNeg;

  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
    if (v == MinNeg) begin
      return MaxPos;
    end else if (v[DATA_W-1]) begin
      return ~v + DATA_W'(1);
    end
    return v;
  endfunction

  logic [DATA_W-1:0] w_abs_l;
  logic [DATA_W-1:0] w_abs_r;
  logic [DATA_W-1:0] w_peak_max;

  always_comb begin
    w_abs_l    = abs_sat(r_hold);
    w_abs_r    = abs_sat(w_word);
    w_peak_max = peak_level;
    if (w_abs_l > w_peak_max) begin
      w_peak_max = w_abs_l;
    end
    if (w_abs_r > w_peak_max) begin
      w_peak_max = w_abs_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_level <= '0;
    end else if (peak_clr) begin
      peak_level <= '0;
    end else if (w_pair) begin
      peak_level <= w_peak_max;
    end
  end
`else
  logic w_pair_unused;
  assign w_pair_unused = w_pair;
`endif

endmodule
